// File: rtl/zxnet_pkg.sv
// Shared constants for the ZX-Spectrum W5300/SL811 bridge: port bytes,
// CTRL/STATUS bit positions, write-capture state encoding and the STATUS packer.
package zxnet_pkg;

  localparam logic [7:0] PORT_LO    = 8'hAB;
  localparam logic [7:0] SL_ADDR_HI = 8'h80;
  localparam logic [7:0] SL_DATA_HI = 8'h81;
  localparam logic [7:0] STAT_HI    = 8'h82;
  localparam logic [7:0] CTRL_HI    = 8'h83;

  localparam int CTRL_W5RST = 7;
  localparam int CTRL_SLRST = 6;
  localparam int CTRL_MAP   = 4;
  localparam int CTRL_W5IE  = 3;
  localparam int CTRL_SLIE  = 2;
  localparam int CTRL_MS    = 0;

  localparam logic [7:0] CTRL_RST_VAL = 8'hC1;

  localparam int STAT_W5INT   = 0;
  localparam int STAT_SLINT   = 1;
  localparam int STAT_ZERO    = 2;
  localparam int STAT_USBPWR  = 3;
  localparam int STAT_BRDY_LO = 4;

  // ARMED: the next CTRL write strobe may update the register.
  // BLOCKED: a write has been taken (or reset hit) and zwr_n must rise first.
  typedef enum logic {
    WR_BLOCKED = 1'b0,
    WR_ARMED   = 1'b1
  } wr_state_e;

  function automatic logic [7:0] status_byte(input logic [3:0] brdy,
                                             input logic       usb_pwr,
                                             input logic       sl_int,
                                             input logic       w5_int_n);
    logic [7:0] s;
    s                              = '0;
    s[STAT_BRDY_LO+3:STAT_BRDY_LO] = brdy;
    s[STAT_USBPWR]                 = usb_pwr;
    s[STAT_ZERO]                   = 1'b0;
    s[STAT_SLINT]                  = sl_int;
    s[STAT_W5INT]                  = !w5_int_n;
    return s;
  endfunction

endpackage

// File: rtl/zx_port_decode.sv
// Combinational Z80 I/O decode for the four bridge ports sharing low byte PORT_LO.
module zx_port_decode
  import zxnet_pkg::*;
(
  input  logic [15:0] za,
  input  logic        ziorq_n,
  output logic        io_hit,
  output logic        sel_ctrl,
  output logic        sel_stat,
  output logic        sel_sl811
);

  logic lo_match;
  logic hi_match;

  always_comb begin
    lo_match  = (za[7:0] == PORT_LO);
    hi_match  = (za[15:8] == SL_ADDR_HI) || (za[15:8] == SL_DATA_HI) ||
                (za[15:8] == STAT_HI)    || (za[15:8] == CTRL_HI);
    io_hit    = !ziorq_n && lo_match && hi_match;
    sel_ctrl  = io_hit && (za[15:8] == CTRL_HI);
    sel_stat  = io_hit && (za[15:8] == STAT_HI);
    // SL811 occupies the 0x80/0x81 pair; a[8] becomes its A0.
    sel_sl811 = io_hit && (za[15:9] == SL_ADDR_HI[7:1]);
  end

endmodule

// File: rtl/zxnet_bus_bridge.sv
// Z80 edge-connector glue for a W5300 and an SL811: CTRL register, chip selects,
// ROM blocking and merged open-drain interrupt. Optional macro: BRDY_STATUS_EN.
module zxnet_bus_bridge
  import zxnet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] za,
  inout  wire  [7:0]  zd,
  input  logic        ziorq_n,
  input  logic        zmreq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        zrfsh_n,
  input  logic        zcsrom_n,
  output logic        ziorqge,
  output logic        zblkrom,
  output wire         zint_n,
  output logic        w5300_rst_n,
  output logic [9:0]  w5300_addr,
  output logic        w5300_cs_n,
  input  logic        w5300_int_n,
  input  logic [3:0]  w5300_brdy,
  output logic        sl811_rst_n,
  output logic        sl811_a0,
  output logic        sl811_cs_n,
  output logic        sl811_ms,
  input  logic        sl811_intrq,
  input  logic        usb_power
);

  logic       io_hit;
  logic       sel_ctrl;
  logic       sel_stat;
  logic       sel_sl811;
  logic [7:0] ctrl;
  logic       wr_req;
  logic       ctrl_we;
  wr_state_e  wr_state;
  wr_state_e  wr_next;
  logic [3:0] brdy_bits;
  logic [7:0] status;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       win;
  logic       irq;

  zx_port_decode u_decode (
    .za        (za),
    .ziorq_n   (ziorq_n),
    .io_hit    (io_hit),
    .sel_ctrl  (sel_ctrl),
    .sel_stat  (sel_stat),
    .sel_sl811 (sel_sl811)
  );

  // Valid/ready on the CTRL write path: a request is (sel_ctrl && !zwr_n);
  // the register is ready only in WR_ARMED, and accepting one transfer blocks
  // further accepts until zwr_n deasserts.
  assign wr_req = sel_ctrl && !zwr_n;

  // Reset leaves the capture blocked so a strobe that straddles reset release
  // is never taken; zwr_n must first return high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state <= WR_BLOCKED;
    else     wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_BLOCKED: if (zwr_n)  wr_next = WR_ARMED;
      WR_ARMED:   if (wr_req) wr_next = WR_BLOCKED;
      default:    wr_next = WR_BLOCKED;
    endcase
  end

  always_comb begin
    ctrl_we = 1'b0;
    case (wr_state)
      WR_ARMED: ctrl_we = wr_req;
      default:  ctrl_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ctrl <= CTRL_RST_VAL;
    else if (ctrl_we) ctrl <= zd;
  end

  assign w5300_rst_n = !ctrl[CTRL_W5RST];
  assign sl811_rst_n = !ctrl[CTRL_SLRST];
  assign sl811_ms    = ctrl[CTRL_MS];

  assign ziorqge    = io_hit;
  assign sl811_a0   = za[8];
  assign sl811_cs_n = !(sel_sl811 && (!zrd_n || !zwr_n));

`ifdef BRDY_STATUS_EN
  assign brdy_bits = w5300_brdy;
`else
  logic unused_brdy;
  assign unused_brdy = ^w5300_brdy;
  assign brdy_bits   = 4'h0;
`endif

  assign status  = status_byte(brdy_bits, usb_power, sl811_intrq, w5300_int_n);
  assign rd_en   = !zrd_n && (sel_ctrl || sel_stat);
  assign rd_data = sel_ctrl ? ctrl : status;
  assign zd      = rd_en ? rd_data : 8'hzz;

  // The W5300 shadows the host ROM; only 10 address lines reach it, so it
  // repeats every 1 KB across the ROM area.
  assign win        = ctrl[CTRL_MAP] && !zmreq_n && zrfsh_n && !zcsrom_n;
  assign zblkrom    = ctrl[CTRL_MAP] && !zcsrom_n;
  assign w5300_cs_n = !(win && (!zrd_n || !zwr_n));
  assign w5300_addr = za[9:0];

  assign irq    = (ctrl[CTRL_W5IE] && !w5300_int_n) ||
                  (ctrl[CTRL_SLIE] && sl811_intrq);
  assign zint_n = irq ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_zxnet_bus_bridge.sv
// Directed bench for zxnet_bus_bridge: Z80 I/O and memory cycles, scoreboard
// of expected values, open-drain/tristate lines observed through pull-ups.
module tb_zxnet_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] za;
  wire  [7:0]  zd;
  logic        ziorq_n, zmreq_n, zrd_n, zwr_n, zrfsh_n, zcsrom_n;
  logic        ziorqge, zblkrom;
  wire         zint_n;
  logic        w5300_rst_n, w5300_cs_n;
  logic [9:0]  w5300_addr;
  logic        w5300_int_n;
  logic [3:0]  w5300_brdy;
  logic        sl811_rst_n, sl811_a0, sl811_cs_n, sl811_ms;
  logic        sl811_intrq, usb_power;

  logic        tb_zd_oe;
  logic [7:0]  tb_zd;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset / bus plumbing ----------------
  always #5 clk = ~clk;

  assign zd = tb_zd_oe ? tb_zd : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (zd[g]);
  end
  pullup (zint_n);

  zxnet_bus_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .za          (za),
    .zd          (zd),
    .ziorq_n     (ziorq_n),
    .zmreq_n     (zmreq_n),
    .zrd_n       (zrd_n),
    .zwr_n       (zwr_n),
    .zrfsh_n     (zrfsh_n),
    .zcsrom_n    (zcsrom_n),
    .ziorqge     (ziorqge),
    .zblkrom     (zblkrom),
    .zint_n      (zint_n),
    .w5300_rst_n (w5300_rst_n),
    .w5300_addr  (w5300_addr),
    .w5300_cs_n  (w5300_cs_n),
    .w5300_int_n (w5300_int_n),
    .w5300_brdy  (w5300_brdy),
    .sl811_rst_n (sl811_rst_n),
    .sl811_a0    (sl811_a0),
    .sl811_cs_n  (sl811_cs_n),
    .sl811_ms    (sl811_ms),
    .sl811_intrq (sl811_intrq),
    .usb_power   (usb_power)
  );

  // ---------------- scoreboard ----------------
  task automatic push_exp(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected queue empty", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [15:0] obs, input logic [15:0] v);
    push_exp(v);
    check(tag, obs);
  endtask

  function automatic logic [7:0] stat_model(input logic [3:0] brdy, input logic usb,
                                            input logic intrq, input logic w5int_n);
    logic [7:0] s;
    s = {4'h0, usb, 1'b0, intrq, ~w5int_n};
`ifdef BRDY_STATUS_EN
    s[7:4] = brdy;
`endif
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    za = 16'h0000; ziorq_n = 1'b1; zmreq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1;
    zrfsh_n = 1'b1; zcsrom_n = 1'b1; tb_zd_oe = 1'b0; tb_zd = 8'h00;
  endtask

  task automatic io_begin(input logic [15:0] a, input logic is_wr, input logic [7:0] d);
    @(negedge clk);
    za = a; ziorq_n = 1'b0;
    if (is_wr) begin
      zwr_n = 1'b0; tb_zd = d; tb_zd_oe = 1'b1;
    end else begin
      zrd_n = 1'b0;
    end
    #1;
  endtask

  task automatic mem_begin(input logic [15:0] a, input logic rfsh);
    @(negedge clk);
    za = a; zmreq_n = 1'b0; zcsrom_n = 1'b0;
    if (rfsh) zrfsh_n = 1'b0;
    else      zrd_n   = 1'b1 ^ 1'b1;
    #1;
  endtask

  task automatic cyc_end();
    @(negedge clk);
    bus_idle();
    #1;
  endtask

  task automatic io_out(input logic [15:0] a, input logic [7:0] d);
    io_begin(a, 1'b1, d);
    cyc_end();
  endtask

  task automatic io_in_check(input string tag, input logic [15:0] a, input logic [7:0] v);
    io_begin(a, 1'b0, 8'h00);
    push_exp({8'h00, v});
    check(tag, {8'h00, zd});
    cyc_end();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus_idle();
    w5300_int_n = 1'b1; w5300_brdy = 4'h0; sl811_intrq = 1'b0; usb_power = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    expect_now("rst_w5_rst_n", {15'b0, w5300_rst_n}, 16'h0000);
    expect_now("rst_sl_rst_n", {15'b0, sl811_rst_n}, 16'h0000);
    expect_now("rst_sl_ms",    {15'b0, sl811_ms},    16'h0001);
    expect_now("rst_cs",       {14'b0, w5300_cs_n, sl811_cs_n}, 16'h0003);
    expect_now("rst_zint",     {15'b0, zint_n}, 16'h0001);
    expect_now("rst_zd_float", {8'h00, zd}, 16'h00FF);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    io_in_check("rd_ctrl_reset", 16'h83AB, 8'hC1);

    // CTRL write held three clocks with data changing after the first edge
    io_begin(16'h83AB, 1'b1, 8'h1C);
    expect_now("wr_pre_edge_rst", {15'b0, w5300_rst_n}, 16'h0000);
    expect_now("wr_ioge",         {15'b0, ziorqge},     16'h0001);
    expect_now("wr_ctrl_no_slcs", {15'b0, sl811_cs_n},  16'h0001);
    @(negedge clk);
    tb_zd = 8'h77;
    repeat (2) @(negedge clk);
    #1;
    expect_now("wr_held_rst", {14'b0, w5300_rst_n, sl811_rst_n}, 16'h0003);
    cyc_end();
    expect_now("idle_ioge", {15'b0, ziorqge}, 16'h0000);
    expect_now("ms_cleared", {15'b0, sl811_ms}, 16'h0000);
    io_in_check("rd_ctrl_1c", 16'h83AB, 8'h1C);

    // SL811 address write then data read
    io_begin(16'h80AB, 1'b1, 8'h05);
    expect_now("sl_wr_cs", {15'b0, sl811_cs_n}, 16'h0000);
    expect_now("sl_wr_a0", {15'b0, sl811_a0},   16'h0000);
    expect_now("sl_wr_ioge", {15'b0, ziorqge},  16'h0001);
    cyc_end();
    expect_now("sl_idle_cs", {15'b0, sl811_cs_n}, 16'h0001);
    io_begin(16'h81AB, 1'b0, 8'h00);
    expect_now("sl_rd_cs", {15'b0, sl811_cs_n}, 16'h0000);
    expect_now("sl_rd_a0", {15'b0, sl811_a0},   16'h0001);
    expect_now("sl_rd_zd_float", {8'h00, zd},   16'h00FF);
    cyc_end();
    expect_now("sl_idle2", {14'b0, sl811_cs_n, ziorqge}, 16'h0002);
    io_in_check("ctrl_after_sl", 16'h83AB, 8'h1C);

    // Memory window with MAP=1
    mem_begin(16'h0123, 1'b0);
    expect_now("win_blk",  {15'b0, zblkrom},    16'h0001);
    expect_now("win_cs",   {15'b0, w5300_cs_n}, 16'h0000);
    expect_now("win_addr", {6'b0, w5300_addr},  16'h0123);
    expect_now("win_ioge", {15'b0, ziorqge},    16'h0000);
    cyc_end();
    mem_begin(16'h2723, 1'b0);
    expect_now("alias_addr", {6'b0, w5300_addr}, 16'h0323);
    expect_now("alias_cs",   {15'b0, w5300_cs_n}, 16'h0000);
    cyc_end();
    mem_begin(16'h0040, 1'b1);
    expect_now("rfsh_cs",  {15'b0, w5300_cs_n}, 16'h0001);
    expect_now("rfsh_blk", {15'b0, zblkrom},    16'h0001);
    cyc_end();

    // MAP=0
    io_out(16'h83AB, 8'h0C);
    mem_begin(16'h0123, 1'b0);
    expect_now("nomap_cs",  {15'b0, w5300_cs_n}, 16'h0001);
    expect_now("nomap_blk", {15'b0, zblkrom},    16'h0000);
    cyc_end();

    // Interrupt merge
    w5300_int_n = 1'b0; #1;
    expect_now("irq_w5_en", {15'b0, zint_n}, 16'h0000);
    io_out(16'h83AB, 8'h04);
    expect_now("irq_w5_masked", {15'b0, zint_n}, 16'h0001);
    sl811_intrq = 1'b1; #1;
    expect_now("irq_sl_en", {15'b0, zint_n}, 16'h0000);
    usb_power = 1'b1; w5300_brdy = 4'hA;
    io_in_check("status_a", 16'h82AB, stat_model(4'hA, 1'b1, 1'b1, 1'b0));
    w5300_int_n = 1'b1; sl811_intrq = 1'b0; usb_power = 1'b0; w5300_brdy = 4'h5;
    #1;
    expect_now("irq_released", {15'b0, zint_n}, 16'h0001);
    io_in_check("status_b", 16'h82AB, stat_model(4'h5, 1'b0, 1'b0, 1'b1));

    // Async reset in the middle of a held write
    io_begin(16'h83AB, 1'b1, 8'h3E);
    @(negedge clk);
    #1;
    expect_now("pre_rst_ms", {14'b0, w5300_rst_n, sl811_ms}, 16'h0002);
    rst = 1'b1;
    #1;
    expect_now("async_rst_now", {13'b0, w5300_rst_n, sl811_rst_n, sl811_ms}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    expect_now("no_wr_after_rst", {13'b0, w5300_rst_n, sl811_rst_n, sl811_ms}, 16'h0001);
    cyc_end();
    io_in_check("rd_ctrl_after_rst", 16'h83AB, 8'hC1);
    io_out(16'h83AB, 8'h3E);
    io_in_check("rd_ctrl_3e", 16'h83AB, 8'h3E);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_drain: observed %0d leftover expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
